// File: rtl/spi_pkg.sv
// Shared types and constants for the multi-select SPI master.
// Mode encoding is {CPOL, CPHA}; the state enum is used by the top FSM.
package spi_pkg;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_t;

    function automatic logic mode_cpol(input spi_mode_t m);
        return m[CPOL_BIT];
    endfunction

    function automatic logic mode_cpha(input spi_mode_t m);
        return m[CPHA_BIT];
    endfunction

endpackage

// File: rtl/spi_sclk_gen_rtl.sv
// SCLK generator: CLK_DIV-cycle half periods and a count of 2*BITS edges.
// While disabled, sclk parks at the CPOL idle level and the counters clear.
// Strobes are combinational and high in the cycle whose closing clock edge
// toggles sclk, so the master acts on the very edge that moves sclk.
module spi_sclk_gen_rtl #(
    parameter int BITS    = 28,
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic cpol,
    output logic sclk,
    output logic lead_stb,
    output logic trail_stb,
    output logic last_edge
);
    import spi_pkg::*;

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW = $clog2(2 * BITS);

    logic [DW-1:0] div_cnt_reg;
    logic [EW-1:0] edge_cnt_reg;
    logic          sclk_reg;
    logic          tick;

    // An edge is due when the divider reaches the end of a half period.
    assign tick      = en && (div_cnt_reg == DW'(CLK_DIV - 1));
    assign lead_stb  = tick && !edge_cnt_reg[0];
    assign trail_stb = tick && edge_cnt_reg[0];
    assign last_edge = tick && (edge_cnt_reg == EW'(2 * BITS - 1));
    assign sclk      = sclk_reg;

    // Divider, edge counter and the sclk level itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
            sclk_reg     <= 1'b0;
        end else if (!en) begin
            div_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
            sclk_reg     <= cpol;
        end else if (tick) begin
            div_cnt_reg  <= '0;
            edge_cnt_reg <= edge_cnt_reg + 1'b1;
            sclk_reg     <= ~sclk_reg;
        end else begin
            div_cnt_reg  <= div_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_mc_rtl.sv
// Multi-select SPI master: one shared SCLK/MOSI/MISO bus, N_SLAVES active-low
// selects, per-transfer CPOL/CPHA and a fixed SCLK divider.
// Optional macro SPI_LSB_FIRST_EN adds i_lsb_first for LSB-first transfers;
// without it every transfer is MSB-first.
module spi_master_mc_rtl
    import spi_pkg::*;
#(
    parameter int BITS     = 28,
    parameter int N_SLAVES = 3,
    parameter int CLK_DIV  = 2,
    parameter int SW       = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
`ifdef SPI_LSB_FIRST_EN
    input  logic                i_lsb_first,
`endif
    input  logic [BITS-1:0]     i_data,
    input  logic                i_send,
    input  logic [SW-1:0]       i_slave_sel,
    input  logic [1:0]          i_mode,
    output logic [BITS-1:0]     o_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    input  logic                i_miso,
    output logic                o_mosi,
    output logic                o_sclk,
    output logic [N_SLAVES-1:0] o_ss
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    spi_state_t          state_reg, state_next;
    logic [DW-1:0]       cnt_reg, cnt_next;
    logic [BITS-1:0]     tx_reg, tx_next;
    logic [BITS-1:0]     rx_reg, rx_next;
    logic [BITS-1:0]     data_reg, data_next;
    logic                mosi_reg, mosi_next;
    logic [SW-1:0]       sel_reg, sel_next;
    spi_mode_t           mode_reg, mode_next;
    logic                lsb_reg, lsb_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic [N_SLAVES-1:0] ss_reg, ss_next;

    logic accept;
    logic req_lsb;
    logic busy_next;
    logic lead_stb, trail_stb, last_edge;
    logic shift_stb, sample_stb;

`ifdef SPI_LSB_FIRST_EN
    assign req_lsb = i_lsb_first;
`else
    assign req_lsb = 1'b0;
`endif

    function automatic logic first_bit(input logic [BITS-1:0] w, input logic lsb);
        return lsb ? w[0] : w[BITS-1];
    endfunction

    function automatic logic [BITS-1:0] shift_word(input logic [BITS-1:0] w, input logic lsb);
        return lsb ? {1'b0, w[BITS-1:1]} : {w[BITS-2:0], 1'b0};
    endfunction

    // The generator runs only in SHIFT; it is given the next mode's CPOL so
    // sclk is already at the new idle level in the first SETUP cycle.
    spi_sclk_gen_rtl #(
        .BITS    (BITS),
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (i_clk),
        .rst       (i_rst),
        .en        (state_reg == SHIFT),
        .cpol      (mode_cpol(mode_next)),
        .sclk      (o_sclk),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .last_edge (last_edge)
    );

    // CPHA=0 samples on leading edges and shifts on trailing; CPHA=1 swaps.
    assign shift_stb  = mode_cpha(mode_reg) ? lead_stb  : trail_stb;
    assign sample_stb = mode_cpha(mode_reg) ? trail_stb : lead_stb;

    // Next-state and datapath updates for the transfer sequencer.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tx_next    = tx_reg;
        rx_next    = rx_reg;
        data_next  = data_reg;
        mosi_next  = mosi_reg;
        sel_next   = sel_reg;
        mode_next  = mode_reg;
        lsb_next   = lsb_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        accept     = i_send && (state_reg == IDLE) && !done_reg;

        case (state_reg)
            IDLE: begin
                mosi_next = 1'b0;
                if (accept) begin
                    if (int'(i_slave_sel) >= N_SLAVES) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = SETUP;
                        cnt_next   = '0;
                        sel_next   = i_slave_sel;
                        mode_next  = spi_mode_t'(i_mode);
                        lsb_next   = req_lsb;
                        rx_next    = '0;
                        if (!i_mode[CPHA_BIT]) begin
                            // First bit must be valid before the first leading edge.
                            mosi_next = first_bit(i_data, req_lsb);
                            tx_next   = shift_word(i_data, req_lsb);
                        end else begin
                            tx_next   = i_data;
                        end
                    end
                end
            end
            SETUP: begin
                if (cnt_reg == DW'(CLK_DIV - 1)) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + 1'b1;
                end
            end
            SHIFT: begin
                if (shift_stb) begin
                    mosi_next = first_bit(tx_reg, lsb_reg);
                    tx_next   = shift_word(tx_reg, lsb_reg);
                end
                if (sample_stb) begin
                    rx_next = lsb_reg ? {i_miso, rx_reg[BITS-1:1]}
                                      : {rx_reg[BITS-2:0], i_miso};
                end
                if (last_edge) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end
            end
            HOLD: begin
                if (cnt_reg == DW'(CLK_DIV - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                    data_next  = rx_reg;
                end else begin
                    cnt_next   = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy_next = (state_next != IDLE);

    // Select decode: only the latched slave goes low, and only while busy.
    genvar gi;
    generate
        for (gi = 0; gi < N_SLAVES; gi++) begin : g_ss
            assign ss_next[gi] = !(busy_next && (sel_next == SW'(gi)));
        end
    endgenerate

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            tx_reg    <= '0;
            rx_reg    <= '0;
            data_reg  <= '0;
            mosi_reg  <= 1'b0;
            sel_reg   <= '0;
            mode_reg  <= MODE0;
            lsb_reg   <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            ss_reg    <= '1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tx_reg    <= tx_next;
            rx_reg    <= rx_next;
            data_reg  <= data_next;
            mosi_reg  <= mosi_next;
            sel_reg   <= sel_next;
            mode_reg  <= mode_next;
            lsb_reg   <= lsb_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            ss_reg    <= ss_next;
        end
    end

    assign o_busy = (state_reg != IDLE);
    assign o_done = done_reg;
    assign o_err  = err_reg;
    assign o_data = data_reg;
    assign o_mosi = mosi_reg;
    assign o_ss   = ss_reg;

endmodule

// File: tb/tb_spi_master_mc_rtl.sv
// Directed bench for spi_master_mc_rtl with a behavioural slave model:
// slaves 0 and 1 return fixed replies, slave 2 is a MOSI->MISO loopback.
module tb_spi_master_mc_rtl;

    localparam logic [27:0] REPLY0 = 28'h1234567;
    localparam logic [27:0] REPLY1 = 28'hBEEF123;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [27:0] i_data;
    logic        i_send;
    logic [1:0]  i_slave_sel;
    logic [1:0]  i_mode;
    logic [27:0] o_data;
    logic        o_busy, o_done, o_err;
    logic        i_miso;
    logic        o_mosi, o_sclk;
    logic [2:0]  o_ss;
`ifdef SPI_LSB_FIRST_EN
    logic        i_lsb_first;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Slave model and monitor state
    logic [27:0] slv_tx = '0;
    logic [27:0] slv_rx = '0;
    logic        slv_miso = 1'b0;
    logic        slv_first = 1'b0;
    int          slv_edges = 0;
    logic [1:0]  cur_mode = 2'b00;
    logic        prev_sclk = 1'b0;
    logic [2:0]  prev_ss = 3'b111;
    logic [27:0] reply;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          multi_ss_cnt = 0;
    int          gap_run = 0;
    int          min_gap = 1000;
    logic        seen_xfer = 1'b0;

    spi_master_mc_rtl #(
        .BITS     (28),
        .N_SLAVES (3),
        .CLK_DIV  (2)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
`ifdef SPI_LSB_FIRST_EN
        .i_lsb_first (i_lsb_first),
`endif
        .i_data      (i_data),
        .i_send      (i_send),
        .i_slave_sel (i_slave_sel),
        .i_mode      (i_mode),
        .o_data      (o_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .i_miso      (i_miso),
        .o_mosi      (o_mosi),
        .o_sclk      (o_sclk),
        .o_ss        (o_ss)
    );

    always #5 i_clk = ~i_clk;

    assign reply  = !o_ss[0] ? REPLY0 : (!o_ss[1] ? REPLY1 : 28'h0);
    assign i_miso = !o_ss[2] ? o_mosi : slv_miso;

    // Slave: sample/shift on sclk edges per the current mode, MSB-first.
    always @(negedge i_clk) begin
        prev_sclk <= o_sclk;
        prev_ss   <= o_ss;
        if (prev_ss == 3'b111 && o_ss != 3'b111) begin
            slv_rx    <= '0;
            slv_edges <= 0;
            if (!cur_mode[0]) begin
                slv_miso <= reply[27];
                slv_tx   <= reply << 1;
            end else begin
                slv_miso <= 1'b0;
                slv_tx   <= reply;
            end
        end else if (o_ss != 3'b111 && o_sclk != prev_sclk) begin
            slv_edges <= slv_edges + 1;
            if ((prev_sclk == cur_mode[1]) != cur_mode[0]) begin
                slv_rx <= {slv_rx[26:0], o_mosi};
                if (slv_rx == '0 && slv_edges < 2) slv_first <= o_mosi;
            end else begin
                slv_miso <= slv_tx[27];
                slv_tx   <= slv_tx << 1;
            end
        end
    end

    // Monitor: pulse counts, select exclusivity, idle gap between transfers.
    always @(negedge i_clk) begin
        if (o_done) done_cnt <= done_cnt + 1;
        if (o_err) err_cnt <= err_cnt + 1;
        if ($countones(~o_ss) > 1) multi_ss_cnt <= multi_ss_cnt + 1;
        if (o_ss == 3'b111) begin
            gap_run <= gap_run + 1;
        end else begin
            if (seen_xfer && gap_run > 0 && gap_run < min_gap) min_gap <= gap_run;
            gap_run   <= 0;
            seen_xfer <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_xfer(input logic [1:0] sel, input logic [1:0] mode, input logic [27:0] data,
                            output logic [27:0] got, output int blen, output logic sclk_setup,
                            output logic [2:0] ss_during, output logic done_seen);
        int guard;
        @(negedge i_clk);
        cur_mode    = mode;
        i_slave_sel = sel;
        i_mode      = mode;
        i_data      = data;
        i_send      = 1'b1;
        @(negedge i_clk);
        i_send     = 1'b0;
        sclk_setup = o_sclk;
        ss_during  = o_ss;
        blen  = 0;
        guard = 0;
        while (o_busy && guard < 1000) begin
            blen++;
            guard++;
            @(negedge i_clk);
        end
        done_seen = o_done;
        got       = o_data;
        $display("xfer sel=%0d mode=%0d tx=%07h rx=%07h busy=%0d done=%0b", sel, mode, data, got, blen, done_seen);
    endtask

    logic [27:0] got;
    int          blen;
    logic        sclk_setup, done_seen;
    logic [2:0]  ss_during;
    logic [27:0] rot_data [3];
    int          guard;
    int          d0;

    initial begin
        i_rst = 1'b1; i_send = 1'b0; i_data = '0; i_slave_sel = '0; i_mode = '0;
`ifdef SPI_LSB_FIRST_EN
        i_lsb_first = 1'b0;
`endif
        repeat (3) @(negedge i_clk);
        check("rst_ss", o_ss, 3'b111);
        check("rst_flags", {o_busy, o_done, o_err, o_mosi, o_sclk}, 5'b0);
        check("rst_data", o_data, 28'h0);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        // Basic MODE0 transfer to slave 0
        run_xfer(2'd0, 2'd0, 28'hA5C3F01, got, blen, sclk_setup, ss_during, done_seen);
        check("m0_ss", ss_during, 3'b110);
        check("m0_busy_len", blen, 116);
        check("m0_done", done_seen, 1'b1);
        check("m0_rx", got, REPLY0);
        check("m0_mosi", slv_rx, 28'hA5C3F01);
        @(negedge i_clk);
        check("m0_done_once", o_done, 1'b0);
        check("m0_hold_data", o_data, REPLY0);

        // All four modes on the loopback slave
        for (int m = 0; m < 4; m++) begin
            run_xfer(2'd2, 2'(m), 28'h0000001, got, blen, sclk_setup, ss_during, done_seen);
            check("mode_sclk_idle", sclk_setup, m[1]);
            check("mode_ss", ss_during, 3'b011);
            check("mode_rx", got, 28'h0000001);
            check("mode_mosi", slv_rx, 28'h0000001);
            check("mode_sclk_end", o_sclk, m[1]);
        end

        // CPHA=1 with a real reply
        run_xfer(2'd1, 2'd3, 28'h5A5A5A5, got, blen, sclk_setup, ss_during, done_seen);
        check("m3_rx", got, REPLY1);
        check("m3_mosi", slv_rx, 28'h5A5A5A5);
        check("m3_ss", ss_during, 3'b101);

        // Invalid slave index
        @(negedge i_clk);
        i_slave_sel = 2'd3; i_send = 1'b1;
        @(negedge i_clk);
        i_send = 1'b0;
        check("bad_err", o_err, 1'b1);
        check("bad_busy", o_busy, 1'b0);
        check("bad_ss", o_ss, 3'b111);
        @(negedge i_clk);
        check("bad_err_pulse", o_err, 1'b0);
        @(negedge i_clk);
        check("bad_err_cnt", err_cnt, 1);
        $display("xfer sel=3 rejected");

        // i_send held high, slaves rotating, data changing mid-transfer
        rot_data[0] = 28'h0F0F0F0; rot_data[1] = 28'h3C3C3C3; rot_data[2] = 28'h7654321;
        @(negedge i_clk);
        cur_mode = 2'd0; i_mode = 2'd0; i_slave_sel = 2'd0; i_data = rot_data[0]; i_send = 1'b1;
        for (int k = 0; k < 3; k++) begin
            guard = 0;
            while (!o_busy && guard < 50) begin guard++; @(negedge i_clk); end
            check("rot_accept", o_busy, 1'b1);
            if (k < 2) begin
                i_slave_sel = 2'(k + 1);
                i_data      = rot_data[k + 1];
            end else begin
                i_send = 1'b0;
                i_data = 28'hFFFFFFF;
            end
            guard = 0;
            while (o_busy && guard < 1000) begin guard++; @(negedge i_clk); end
            check("rot_done", o_done, 1'b1);
            check("rot_rx", o_data, (k == 0) ? REPLY0 : ((k == 1) ? REPLY1 : rot_data[2]));
            check("rot_mosi", slv_rx, rot_data[k]);
            $display("xfer rot sel=%0d tx=%07h rx=%07h", k, rot_data[k], o_data);
        end
        repeat (4) @(negedge i_clk);
        check("rot_no_extra", o_busy, 1'b0);
        check("rot_gap_ge2", (min_gap >= 2), 1'b1);

        // Reset in the middle of SHIFT
        @(negedge i_clk);
        cur_mode = 2'd0; i_mode = 2'd0; i_slave_sel = 2'd0; i_data = 28'h1111111; i_send = 1'b1;
        @(negedge i_clk);
        i_send = 1'b0;
        guard = 0;
        while (slv_edges < 20 && guard < 200) begin guard++; @(negedge i_clk); end
        check("rst_mid_reached", (slv_edges >= 20), 1'b1);
        d0 = done_cnt;
        i_rst = 1'b1;
        @(negedge i_clk);
        check("rst_mid_ss", o_ss, 3'b111);
        check("rst_mid_sclk", o_sclk, 1'b0);
        check("rst_mid_busy", o_busy, 1'b0);
        i_rst = 1'b0;
        repeat (130) @(negedge i_clk);
        check("rst_mid_no_done", done_cnt, d0);
        $display("xfer aborted by reset");

`ifdef SPI_LSB_FIRST_EN
        i_lsb_first = 1'b1;
        run_xfer(2'd2, 2'd0, 28'h0000001, got, blen, sclk_setup, ss_during, done_seen);
        check("lsb_first_bit", slv_first, 1'b1);
        check("lsb_rx", got, 28'h0000001);
        i_lsb_first = 1'b0;
`endif

        check("one_ss_low", multi_ss_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
